// File: rtl/pu_riscv_csr_file.sv
// Machine-mode CSR file: combinational read/decode, edge-committed writes,
// cycle/instret counters and trap-entry / MRET updates of mstatus, mepc and mcause.
module pu_riscv_csr_file #(
    parameter int              XLEN       = 64,
    parameter bit              HAS_RVC    = 1'b1,
    parameter logic [XLEN-1:0] MTVEC_INIT = 'h200,
    parameter logic [XLEN-1:0] HARTID     = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ex_stall,
    input  logic [11:0]     ex_csr_reg,
    input  logic            ex_csr_we,
    input  logic [XLEN-1:0] ex_csr_wval,
    output logic [XLEN-1:0] st_csr_rval,
    output logic            st_csr_illegal,
    output logic [1:0]      st_xlen,
    input  logic            wb_retire,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_req,
    output logic [XLEN-1:0] st_mtvec,
    output logic [XLEN-1:0] st_mepc,
    output logic            st_mie
);
    localparam logic [1:0] RV32I = 2'b01;
    localparam logic [1:0] RV64I = 2'b10;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [1:0]      XL        = (XLEN == 32) ? RV32I : RV64I;
    localparam logic [25:0]     MISA_EXT  = 26'h100 | (HAS_RVC ? 26'h4 : 26'h0);
    localparam logic [XLEN-1:0] MISA_VAL  = {XL, {(XLEN-28){1'b0}}, MISA_EXT};
    // Without RVC every PC is 4-byte aligned, so mepc[1] is dropped too.
    localparam logic [XLEN-1:0] EPC_MASK  = HAS_RVC ? ~XLEN'(1) : ~XLEN'(3);
    localparam logic [XLEN-1:0] TVEC_MASK = ~XLEN'(3);

    logic            mie, mpie;
    logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mcycle, minstret;
    logic            impl, ro, wr;

    always_comb begin
        st_csr_rval = '0;
        impl        = 1'b1;
        case (ex_csr_reg)
            CSR_MSTATUS:              st_csr_rval = XLEN'({mpie, 3'b000, mie, 3'b000});
            CSR_MISA:                 st_csr_rval = MISA_VAL;
            CSR_MTVEC:                st_csr_rval = mtvec;
            CSR_MSCRATCH:             st_csr_rval = mscratch;
            CSR_MEPC:                 st_csr_rval = mepc;
            CSR_MCAUSE:               st_csr_rval = mcause;
            CSR_MCYCLE, CSR_CYCLE:    st_csr_rval = mcycle;
            CSR_MINSTRET, CSR_INSTRET: st_csr_rval = minstret;
            CSR_MHARTID:              st_csr_rval = HARTID;
            default:                  impl = 1'b0;
        endcase
        ro             = (ex_csr_reg[11:10] == 2'b11) || (ex_csr_reg == CSR_MISA);
        st_csr_illegal = !impl || (ex_csr_we && ro);
        wr             = ex_csr_we && !ex_stall && impl && !ro;
    end

    assign st_xlen  = XL;
    assign st_mtvec = mtvec;
    assign st_mepc  = mepc;
    assign st_mie   = mie;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= MTVEC_INIT & TVEC_MASK;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            // trap > mret > CSR write for the trap-owned registers
            if (trap_req) begin
                mpie   <= mie;
                mie    <= 1'b0;
                mepc   <= trap_pc & EPC_MASK;
                mcause <= trap_cause;
            end else begin
                if (mret_req) begin
                    mie  <= mpie;
                    mpie <= 1'b1;
                end else if (wr && ex_csr_reg == CSR_MSTATUS) begin
                    mie  <= ex_csr_wval[3];
                    mpie <= ex_csr_wval[7];
                end
                if (wr && ex_csr_reg == CSR_MEPC)   mepc   <= ex_csr_wval & EPC_MASK;
                if (wr && ex_csr_reg == CSR_MCAUSE) mcause <= ex_csr_wval;
            end

            if (wr && ex_csr_reg == CSR_MTVEC)    mtvec    <= ex_csr_wval & TVEC_MASK;
            if (wr && ex_csr_reg == CSR_MSCRATCH) mscratch <= ex_csr_wval;

            // a committed counter write replaces that cycle's increment
            if (wr && ex_csr_reg == CSR_MCYCLE) mcycle <= ex_csr_wval;
            else                                mcycle <= mcycle + 1'b1;

            if (wr && ex_csr_reg == CSR_MINSTRET) minstret <= ex_csr_wval;
            else if (wb_retire)                   minstret <= minstret + 1'b1;
        end
    end
endmodule
